// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Program counter register plus single-outstanding instruction
//             fetch over a req/ack handshake, with timeout abort.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  branch_zero,
    input  logic                  fetch_start,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [25:0]           imm26,
    output logic                  instr_valid,
    output logic                  fetch_err,
    output logic                  busy
);

    // Counter only has to reach TIMEOUT-1, but keep at least 4 bits.
    localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        pc_d    = (pc_write | (pc_write_cond & branch_zero)) ? pc_next : pc_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    state_d = ST_REQ;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                // An ack on the expiry cycle takes priority over the abort.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = addr_q;
    assign imem_req    = req_q;
    assign instr       = instr_q;
    assign imm26       = instr_q[25:0];
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign busy        = (state_q == ST_REQ);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Directed plus randomized check of pc_fetch_unit against a
//             transaction-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_next;
    logic        pc_write, pc_write_cond, branch_zero, fetch_start;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, pc;
    logic [31:0] imem_rdata, instr;
    logic [25:0] imm26;
    logic        instr_valid, fetch_err, busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_err    = 0;

    // Reference model state
    logic [15:0] m_pc, m_addr;
    logic [31:0] m_instr;
    bit          m_busy, m_valid, m_err;
    int          m_wait;

    pc_fetch_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_zero(branch_zero),
        .fetch_start(fetch_start), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .instr(instr),
        .imm26(imm26), .instr_valid(instr_valid), .fetch_err(fetch_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_addr = 16'h0000; m_instr = 32'h0;
        m_busy = 0; m_valid = 0; m_err = 0; m_wait = 0;
    endtask

    // One clock edge worth of behaviour, using the inputs present at the edge.
    task automatic model_edge();
        logic [15:0] old_pc;
        old_pc  = m_pc;
        m_valid = 0;
        m_err   = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            m_wait++;
            if (imem_ack) begin
                m_instr = imem_rdata; m_valid = 1; m_busy = 0;
            end else if (m_wait == TIMEOUT) begin
                m_err = 1; m_busy = 0;
            end
        end else if (fetch_start) begin
            m_busy = 1; m_addr = old_pc; m_wait = 0;
        end
        if (pc_write || (pc_write_cond && branch_zero)) m_pc = pc_next;
    endtask

    task automatic check_all();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("instr", 64'(instr), 64'(m_instr));
        chk("imm26", 64'(imm26), 64'(m_instr[25:0]));
        chk("imem_req", 64'(imem_req), 64'(m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("imem_addr", 64'(imem_addr), 64'(m_addr));
        chk("instr_valid", 64'(instr_valid), 64'(m_valid));
        chk("fetch_err", 64'(fetch_err), 64'(m_err));
        if (instr_valid) n_valid++;
        if (fetch_err) n_err++;
    endtask

    task automatic cycle(input logic pw, input logic pwc, input logic bz,
                         input logic [15:0] pn, input logic fs,
                         input logic ack, input logic [31:0] rd);
        pc_write = pw; pc_write_cond = pwc; branch_zero = bz; pc_next = pn;
        fetch_start = fs; imem_ack = ack; imem_rdata = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'hDEAD, 0, 0, 32'hBAD0_BAD0);
    endtask

    initial begin
        rst_n = 1'b0;
        pc_write = 0; pc_write_cond = 0; branch_zero = 0; pc_next = '0;
        fetch_start = 0; imem_ack = 0; imem_rdata = '0;
        model_reset();

        // Reset state and quiet idle
        idle(2);
        rst_n = 1'b1;
        idle(5);

        // Load pc, fetch, ack three cycles later
        cycle(1, 0, 0, 16'h0040, 0, 0, 32'h0);
        n_valid = 0;
        cycle(0, 0, 0, 16'h0000, 1, 0, 32'h0);
        chk("t2_addr", 64'(imem_addr), 64'h0040);
        cycle(0, 0, 0, 16'h0000, 0, 0, 32'h0);
        cycle(0, 0, 0, 16'h0000, 0, 0, 32'h0);
        cycle(0, 0, 0, 16'h0000, 0, 1, 32'h0800_0123);
        chk("t2_instr", 64'(instr), 64'h0800_0123);
        chk("t2_imm26", 64'(imm26), 64'h000_0123);
        idle(3);
        chk("t2_valid_cnt", 64'(n_valid), 64'd1);

        // Conditional pc load
        cycle(0, 1, 0, 16'h0100, 0, 0, 32'h0);
        chk("t3_hold", 64'(pc), 64'h0040);
        cycle(0, 1, 1, 16'h0100, 0, 0, 32'h0);
        chk("t3_load", 64'(pc), 64'h0100);

        // Timeout abort, then ack on the exact expiry cycle
        n_err = 0;
        cycle(0, 0, 0, 16'h0, 1, 0, 32'h0);
        for (int i = 0; i < TIMEOUT; i++) cycle(0, 0, 0, 16'h0, 0, 0, 32'h0);
        chk("t4_err_cnt", 64'(n_err), 64'd1);
        chk("t4_req_low", 64'(imem_req), 64'd0);
        chk("t4_instr_hold", 64'(instr), 64'h0800_0123);
        n_err = 0; n_valid = 0;
        cycle(0, 0, 0, 16'h0, 1, 0, 32'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0, 16'h0, 0, 0, 32'h0);
        cycle(0, 0, 0, 16'h0, 0, 1, 32'hCAFE_F00D);
        idle(2);
        chk("t4_expiry_err", 64'(n_err), 64'd0);
        chk("t4_expiry_valid", 64'(n_valid), 64'd1);
        chk("t4_expiry_instr", 64'(instr), 64'hCAFE_F00D);

        // pc write and second fetch_start while busy
        n_valid = 0;
        cycle(0, 0, 0, 16'h0, 1, 0, 32'h0);
        cycle(1, 0, 0, 16'h0200, 1, 0, 32'h0);
        chk("t5_pc", 64'(pc), 64'h0200);
        chk("t5_addr", 64'(imem_addr), 64'h0100);
        cycle(0, 0, 0, 16'h0, 0, 1, 32'h1234_5678);
        idle(4);
        chk("t5_one_fetch", 64'(n_valid), 64'd1);

        // Async reset mid-fetch, late ack ignored
        cycle(0, 0, 0, 16'h0, 1, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 64'(imem_req), 64'd0);
        chk("t6_pc_async", 64'(pc), 64'h0000);
        model_reset();
        idle(1);
        rst_n = 1'b1;
        cycle(0, 0, 0, 16'h0, 0, 1, 32'hFFFF_FFFF);
        chk("t6_late_ack", 64'(instr), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  16'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
